int_controller: RTL

//  Interrupt controller for the RAT MCU's single interrupt input. It collects up to 8

---
 rtl/intc_pkg.sv | 25 ++
 rtl/intc_edge_sync.sv | 31 +++
 rtl/int_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared types and port map for the RAT MCU interrupt controller.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } intc_state_t;

  localparam logic [7:0] STATUS_ID = 8'h30;
  localparam logic [7:0] CAUSE_ID  = 8'h31;
  localparam logic [7:0] ENABLE_ID = 8'h82;
  localparam logic [7:0] ACK_ID    = 8'h83;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intc_edge_sync.sv
// intc_edge_sync: brings one asynchronous request line into the CLK domain
// and emits a single-cycle pulse for each rising edge seen on it.
module intc_edge_sync
  import intc_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic irq,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Two metastability flops followed by one history flop for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/int_controller.sv
// int_controller: collects up to 8 request lines, latches their rising edges
// as pending bits and serves them one at a time by lowest index, driving one
// INTR pulse per served request. Enable/ack are written and status/cause read
// over the MCU port bus.
// Optional feature: define INTC_TIMEOUT_EN to re-pulse INTR for the same cause
// after ACK_TIMEOUT cycles in WAIT_ACK without an ack; when undefined WAIT_ACK
// waits indefinitely.
module int_controller
  import intc_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int PULSE_LEN   = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_DATA,
  output logic             IN_SEL,
  output logic             INTR
);

  localparam int PCNT_W = (PULSE_LEN > 2) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_LEN - 1);

  if (N_SRC < 1 || N_SRC > 8 || PULSE_LEN < 2 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("int_controller: illegal parameter set");
  end

  if (N_SRC < 8) begin : g_unused
    logic unused_out_bits;
    assign unused_out_bits = ^OUT_PORT[7:N_SRC];
  end

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] ack_mask;
  logic [7:0]       pending8;
  logic [7:0]       req8;
  logic             enable_wr;
  logic             ack_wr;
  logic             busy;

  intc_state_t       state_q;
  intc_state_t       state_d;
  logic [2:0]        cause_q;
  logic [2:0]        cause_d;
  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;
  logic              intr_q;
  logic              intr_d;

`ifdef INTC_TIMEOUT_EN
  localparam int WCNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(ACK_TIMEOUT - 1);
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
`endif

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    intc_edge_sync u_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .irq   (IRQ[i]),
      .rise  (rise[i])
    );
  end

  assign enable_wr = IO_STRB && (PORT_ID == ENABLE_ID);
  assign ack_wr    = IO_STRB && (PORT_ID == ACK_ID);
  assign ack_mask  = ack_wr ? OUT_PORT[N_SRC-1:0] : '0;

  // Pending bits: a fresh edge wins over an ack landing in the same cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_mask) | rise;
    end
  end

  // Enable register; masked sources keep latching but never raise INTR
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      enable_q <= '0;
    end else if (enable_wr) begin
      enable_q <= OUT_PORT[N_SRC-1:0];
    end
  end

  // Widen pending/request vectors to the 8-bit bus and priority-encoder width
  always_comb begin
    pending8 = '0;
    req8     = '0;
    pending8[N_SRC-1:0] = pending_q;
    req8[N_SRC-1:0]     = pending_q & enable_q;
  end

  // Serving FSM state, latched cause, pulse counter and registered INTR
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cause_q <= '0;
      pcnt_q  <= '0;
      intr_q  <= 1'b0;
`ifdef INTC_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pcnt_q  <= pcnt_d;
      intr_q  <= intr_d;
`ifdef INTC_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  // Next state: cause is latched only when leaving IDLE, so enable changes
  // during service cannot redirect it; WAIT_ACK leaves only on the ack
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pcnt_d  = pcnt_q;
`ifdef INTC_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req8 != 8'h00) begin
          state_d = PULSE;
          cause_d = lowest_set(req8);
          pcnt_d  = PULSE_LAST;
        end
      end
      PULSE: begin
        if (pcnt_q == '0) begin
          state_d = WAIT_ACK;
`ifdef INTC_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (!pending8[cause_q]) begin
          state_d = IDLE;
        end
`ifdef INTC_TIMEOUT_EN
        else if (wcnt_q == TIMEOUT_LAST) begin
          state_d = PULSE;
          pcnt_d  = PULSE_LAST;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    intr_d = (state_d == PULSE);
  end

  assign busy = (state_q != IDLE);
  assign INTR = intr_q;

  // Read mux; IN_SEL steers the wrapper's input mux to this block
  always_comb begin
    IN_DATA = 8'h00;
    IN_SEL  = 1'b0;
    if (PORT_ID == STATUS_ID) begin
      IN_DATA = pending8;
      IN_SEL  = 1'b1;
    end else if (PORT_ID == CAUSE_ID) begin
      IN_DATA = {busy, 4'b0000, cause_q};
      IN_SEL  = 1'b1;
    end
  end

endmodule
